// File: rtl/apu_audio_out.sv
// apu_audio_out: AHB-Lite programmed audio engine. Frames pushed into a small
// FIFO are popped once per sample period. Each channel drives a 1-bit pin
// through either a PWM comparator or a first-order sigma-delta modulator.
module apu_audio_out #(
  parameter int N_CHAN     = 2,
  parameter int W_SAMPLE   = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int W_DIV      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic [31:0]       ahbls_hwdata,
  output logic [31:0]       ahbls_hrdata,
  output logic              irq,
  output logic [N_CHAN-1:0] audio_out
);

  localparam int FRAME_W = N_CHAN * W_SAMPLE;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] A_CSR  = 2'd0;
  localparam logic [1:0] A_DIV  = 2'd1;
  localparam logic [1:0] A_FIFO = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  // AHB data-phase registers
  logic [1:0] addr_p1;
  logic       write_p1;
  logic       vld_p1;

  // Control registers
  logic              en;
  logic              mode;
  logic              irq_en;
  logic [3:0]        thresh;
  logic [W_DIV-1:0]  div;

  // Frame FIFO
  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [LVL_W-1:0]   level;
  logic [7:0]         level8;
  logic               uf;
  logic               of;

  // Sample-rate divider and modulators
  logic [W_DIV-1:0]    cnt;
  logic                en_q;
  logic [W_SAMPLE-1:0] ramp;
  logic [W_SAMPLE-1:0] cur [N_CHAN];
  logic [W_SAMPLE:0]   acc [N_CHAN];
  logic [W_SAMPLE:0]   sum [N_CHAN];
  logic [N_CHAN-1:0]   out_q;
  logic                irq_q;

  logic wr_p1, rd_p1, wr_csr, wr_div, wr_fifo, wr_stat, flush;
  logic full, empty, tick, pop, push_ok, ovf_set;
  logic unused_bits;

  assign wr_p1   = vld_p1 & write_p1;
  assign rd_p1   = vld_p1 & ~write_p1;
  assign wr_csr  = wr_p1 & (addr_p1 == A_CSR);
  assign wr_div  = wr_p1 & (addr_p1 == A_DIV);
  assign wr_fifo = wr_p1 & (addr_p1 == A_FIFO);
  assign wr_stat = wr_p1 & (addr_p1 == A_STAT);
  assign flush   = wr_csr & ahbls_hwdata[3];

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign level8  = 8'(level);
  // en_q gates the first enabled cycle so the counter loads DIV before ticking
  assign tick    = en & en_q & (cnt == '0);
  assign pop     = tick & ~empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign push_ok = wr_fifo & (~full | pop);
  assign ovf_set = wr_fifo & full & ~pop;

  assign ahbls_hready_resp = 1'b1;
  assign ahbls_hresp       = 1'b0;
  assign irq               = irq_q;
  assign audio_out         = out_q;
  assign unused_bits       = ^{ahbls_hsize, ahbls_haddr[15:4], ahbls_haddr[1:0], ahbls_hwdata};

  // Address phase -> data phase: capture the transfer when the bus advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p1  <= '0;
      write_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (ahbls_hready) begin
      addr_p1  <= ahbls_haddr[3:2];
      write_p1 <= ahbls_hwrite;
      vld_p1   <= ahbls_htrans[1];
    end
  end

  // CSR and DIV writes land at the end of the data phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en     <= 1'b0;
      mode   <= 1'b0;
      irq_en <= 1'b0;
      thresh <= '0;
      div    <= '0;
    end else begin
      if (wr_csr) begin
        en     <= ahbls_hwdata[0];
        mode   <= ahbls_hwdata[1];
        irq_en <= ahbls_hwdata[2];
        thresh <= ahbls_hwdata[11:8];
      end
      if (wr_div) div <= ahbls_hwdata[W_DIV-1:0];
    end
  end

  // FIFO pointers and level; flush overrides any pop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (pop)     rptr <= rptr + 1'b1;
      if (push_ok) wptr <= wptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // FIFO storage holds frame data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= ahbls_hwdata[FRAME_W-1:0];
  end

  // Sticky error flags: hardware set wins over a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf <= 1'b0;
      of <= 1'b0;
    end else begin
      if (tick & empty)                     uf <= 1'b1;
      else if (wr_stat & ahbls_hwdata[10])  uf <= 1'b0;
      if (ovf_set)                          of <= 1'b1;
      else if (wr_stat & ahbls_hwdata[11])  of <= 1'b0;
    end
  end

  // Sample-period down-counter; a new DIV is only picked up at reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      en_q <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (!en_q || cnt == '0) cnt <= div;
      else                    cnt <= cnt - 1'b1;
    end
  end

  // Sigma-delta adder: low bits of the accumulator plus the current sample
  always_comb begin
    for (int n = 0; n < N_CHAN; n++) begin
      sum[n] = {1'b0, acc[n][W_SAMPLE-1:0]} + {1'b0, cur[n]};
    end
  end

  // Modulators: ramp and accumulators run in both modes, output is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp  <= '0;
      out_q <= '0;
      for (int n = 0; n < N_CHAN; n++) begin
        cur[n] <= '0;
        acc[n] <= '0;
      end
    end else if (!en) begin
      ramp  <= '0;
      out_q <= '0;
      for (int n = 0; n < N_CHAN; n++) begin
        cur[n] <= '0;
        acc[n] <= '0;
      end
    end else begin
      ramp <= ramp + 1'b1;
      for (int n = 0; n < N_CHAN; n++) begin
        if (pop) cur[n] <= mem[rptr][n*W_SAMPLE +: W_SAMPLE];
        acc[n]   <= sum[n];
        out_q[n] <= mode ? sum[n][W_SAMPLE] : (cur[n] > ramp);
      end
    end
  end

  // Level interrupt, one cycle behind LEVEL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_en & (level8 <= 8'(thresh));
  end

  // Combinational read data during the data phase
  always_comb begin
    ahbls_hrdata = '0;
    if (rd_p1) begin
      case (addr_p1)
        A_CSR:   ahbls_hrdata = {20'd0, thresh, 4'd0, 1'b0, irq_en, mode, en};
        A_DIV:   ahbls_hrdata = 32'(div);
        A_STAT:  ahbls_hrdata = {20'd0, of, uf, empty, full, level8};
        default: ahbls_hrdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apu_audio_out.sv
// tb_apu_audio_out: randomized bench with a queue-based behavioural model of
// the audio engine, compared against the DUT outputs every cycle.
module tb_apu_audio_out;

  localparam int N_CHAN     = 2;
  localparam int W_SAMPLE   = 12;
  localparam int FIFO_DEPTH = 8;
  localparam int W_DIV      = 12;
  localparam int SMAX       = 1 << W_SAMPLE;
  localparam int FRAME_W    = N_CHAN * W_SAMPLE;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       haddr = '0;
  logic              hwrite = 1'b0;
  logic [1:0]        htrans = '0;
  logic [2:0]        hsize = 3'b010;
  logic              hready = 1'b1;
  logic              hready_resp;
  logic              hresp;
  logic [31:0]       hwdata = '0;
  logic [31:0]       hrdata;
  logic              irq;
  logic [N_CHAN-1:0] audio_out;

  apu_audio_out #(
    .N_CHAN(N_CHAN), .W_SAMPLE(W_SAMPLE), .FIFO_DEPTH(FIFO_DEPTH), .W_DIV(W_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans),
    .ahbls_hsize(hsize), .ahbls_hready(hready),
    .ahbls_hready_resp(hready_resp), .ahbls_hresp(hresp),
    .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata),
    .irq(irq), .audio_out(audio_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]       q[$];
  bit                m_en, m_mode, m_irqen, m_uf, m_of;
  int                m_thresh, m_div;
  int                m_cnt;          // -1: divider must load DIV before counting
  int                m_ramp;
  int                m_cur[N_CHAN];
  int                m_acc[N_CHAN];
  logic [N_CHAN-1:0] m_out;
  bit                m_irq;
  bit                ap_vld, ap_wr;
  logic [1:0]        ap_addr;
  logic [31:0]       fmask;

  task automatic model_reset();
    q.delete();
    m_en = 0; m_mode = 0; m_irqen = 0; m_uf = 0; m_of = 0;
    m_thresh = 0; m_div = 0; m_cnt = -1; m_ramp = 0;
    for (int n = 0; n < N_CHAN; n++) begin
      m_cur[n] = 0;
      m_acc[n] = 0;
    end
    m_out = '0; m_irq = 0;
    ap_vld = 0; ap_wr = 0; ap_addr = '0;
  endtask

  task automatic model_step();
    bit                tick, set_uf, nirq;
    logic [N_CHAN-1:0] nout;
    logic [31:0]       front;
    fmask  = (32'd1 << FRAME_W) - 32'd1;
    tick   = m_en && (m_cnt == 0);
    set_uf = 0;
    nirq   = m_irqen && (q.size() <= m_thresh);
    for (int n = 0; n < N_CHAN; n++) begin
      if (!m_en)       nout[n] = 1'b0;
      else if (m_mode) nout[n] = (m_acc[n] + m_cur[n]) >= SMAX;
      else             nout[n] = m_cur[n] > m_ramp;
    end
    if (!m_en) begin
      m_cnt = -1; m_ramp = 0;
      for (int n = 0; n < N_CHAN; n++) begin
        m_cur[n] = 0;
        m_acc[n] = 0;
      end
    end else begin
      for (int n = 0; n < N_CHAN; n++) m_acc[n] = (m_acc[n] + m_cur[n]) % SMAX;
      m_ramp = (m_ramp + 1) % SMAX;
      if (tick) begin
        if (q.size() > 0) begin
          front = q.pop_front();
          for (int n = 0; n < N_CHAN; n++)
            m_cur[n] = int'((front >> (n * W_SAMPLE)) & 32'(SMAX - 1));
        end else begin
          set_uf = 1;
        end
      end
      m_cnt = (m_cnt <= 0) ? m_div : m_cnt - 1;
    end
    if (ap_vld && ap_wr) begin
      case (ap_addr)
        2'd0: begin
          if (hwdata[3]) q.delete();
          m_en = hwdata[0]; m_mode = hwdata[1]; m_irqen = hwdata[2];
          m_thresh = int'(hwdata[11:8]);
        end
        2'd1: m_div = int'(hwdata[W_DIV-1:0]);
        2'd2: begin
          if (q.size() < FIFO_DEPTH) q.push_back(hwdata & fmask);
          else m_of = 1;
        end
        default: begin
          if (hwdata[10]) m_uf = 0;
          if (hwdata[11]) m_of = 0;
        end
      endcase
    end
    if (set_uf) m_uf = 1;
    if (hready) begin
      ap_vld = htrans[1]; ap_wr = hwrite; ap_addr = haddr[3:2];
    end
    m_out = nout;
    m_irq = nirq;
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: begin
        v[0] = m_en; v[1] = m_mode; v[2] = m_irqen; v[11:8] = 4'(m_thresh);
      end
      2'd1: v = 32'(m_div);
      2'd3: begin
        v[7:0] = 8'(q.size());
        v[8]   = (q.size() == FIFO_DEPTH);
        v[9]   = (q.size() == 0);
        v[10]  = m_uf;
        v[11]  = m_of;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Every-cycle output comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      check("audio_out", 32'(audio_out), 32'(m_out));
      check("irq", 32'(irq), 32'(m_irq));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    haddr = {12'd0, a, 2'b00}; hwrite = 1'b1; htrans = 2'b10;
    @(negedge clk);
    htrans = 2'b00; hwrite = 1'b0; hwdata = d;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    haddr = {12'd0, a, 2'b00}; hwrite = 1'b0; htrans = 2'b10;
    @(negedge clk);
    htrans = 2'b00;
    d = hrdata;
  endtask

  task automatic rd_lit(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic rd_model(input string name, input logic [1:0] a);
    logic [31:0] d;
    rd(a, d);
    check(name, d, m_reg(a));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic duty(input int n, output int c0, output int c1);
    c0 = 0; c1 = 0;
    repeat (n) begin
      @(negedge clk);
      c0 += int'(audio_out[0]);
      c1 += int'(audio_out[1]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, guard;
    logic [31:0] d;
    logic [31:0] c;
    int r;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_audio", 32'(audio_out), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    rst_n = 1'b1;
    cmp_on = 1'b1;
    rd_lit("rst_csr", 2'd0, 32'h0);
    rd_lit("rst_div", 2'd1, 32'h0);
    rd_lit("rst_fifo", 2'd2, 32'h0);
    rd_lit("rst_stat", 2'd3, 32'h200);

    // Overflow with EN=0
    for (int i = 0; i < 9; i++) wr(2'd2, 32'(i * 16 + 1));
    rd_lit("ovf_stat", 2'd3, 32'h908);
    wr(2'd3, 32'h800);
    rd_lit("ovf_w1c", 2'd3, 32'h108);
    wr(2'd0, 32'h8);
    rd_lit("flush_stat", 2'd3, 32'h200);

    // PWM duty 2048/4096 and 1024/4096 with DIV=99
    wr(2'd1, 32'd99);
    for (int i = 0; i < 3; i++) wr(2'd2, 32'h0040_0800);
    wr(2'd0, 32'h1);
    idle(110);
    duty(4096, c0, c1);
    check("pwm_duty_ch0", 32'(c0), 32'd2048);
    check("pwm_duty_ch1", 32'(c1), 32'd1024);
    wr(2'd0, 32'h8);
    wr(2'd3, 32'hC00);
    rd_lit("stat_clean", 2'd3, 32'h200);

    // PWM boundaries: full-scale and zero samples
    wr(2'd2, 32'h0000_0FFF);
    wr(2'd0, 32'h1);
    idle(110);
    duty(4096, c0, c1);
    check("pwm_full_scale", 32'(c0), 32'd4095);
    check("pwm_zero", 32'(c1), 32'd0);
    wr(2'd0, 32'h8);
    wr(2'd3, 32'hC00);

    // Underflow: one frame, DIV=3
    wr(2'd1, 32'd3);
    wr(2'd2, 32'h0045_6123);
    wr(2'd0, 32'h1);
    idle(15);
    rd_lit("uf_stat", 2'd3, 32'h600);
    wr(2'd0, 32'h8);
    wr(2'd3, 32'h400);

    // Sigma-delta: 0x400 -> one high per four cycles; 0 -> always low
    wr(2'd1, 32'd9);
    wr(2'd2, 32'h0000_0400);
    wr(2'd2, 32'h0000_0400);
    wr(2'd0, 32'h3);
    idle(20);
    duty(4096, c0, c1);
    check("sd_quarter", 32'(c0), 32'd1024);
    check("sd_zero", 32'(c1), 32'd0);
    wr(2'd0, 32'h8);
    wr(2'd3, 32'hC00);

    // IRQ threshold
    wr(2'd1, 32'd9);
    for (int i = 0; i < 4; i++) wr(2'd2, 32'(i * 256 + 32'h100));
    wr(2'd0, 32'h205);
    guard = 0;
    while (irq !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("irq_rise_in_time", 32'(guard < 300), 32'd1);
    rd(2'd3, d);
    check("irq_level", 32'(d[7:0]), 32'd2);
    wr(2'd2, 32'h0000_0333);
    idle(2);
    check("irq_fall", 32'(irq), 32'd0);
    wr(2'd0, 32'h20D);
    idle(2);
    check("irq_flush", 32'(irq), 32'd1);
    rd(2'd3, d);
    check("flush_level", 32'(d[9:0]), 32'h200);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        wr(2'd2, $urandom);
      end else if (r < 50) begin
        wr(2'd1, 32'($urandom_range(0, 15)));
      end else if (r < 65) begin
        c = '0;
        c[0] = ($urandom_range(0, 7) != 0);
        c[1] = 1'($urandom_range(0, 1));
        c[2] = 1'($urandom_range(0, 1));
        c[3] = ($urandom_range(0, 9) == 0);
        c[11:8] = 4'($urandom_range(0, 9));
        wr(2'd0, c);
      end else if (r < 90) begin
        rd_model("rand_read", 2'($urandom_range(0, 3)));
      end else if (r < 95) begin
        wr(2'd3, {20'd0, 2'($urandom_range(0, 3)), 10'd0});
      end else begin
        idle(int'($urandom_range(0, 20)));
      end
    end
    rd_model("final_stat", 2'd3);
    rd_model("final_csr", 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
